// File: rtl/dpram_stream_reader_pkg.sv
// Shared definitions for the dual-port RAM ring-buffer reader and its writer-side peer.
// Holds the ring pointer-difference helper and the stream word width constant.
package dpram_stream_reader_pkg;

    localparam int STREAM_DATA_W = 32;
    localparam int PTR_MAX_W     = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Occupancy between two ring pointers, modulo 2**ptr_w; the writer uses the same helper for its full check.
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(
        input logic [PTR_MAX_W-1:0] a,
        input logic [PTR_MAX_W-1:0] b,
        input int unsigned          ptr_w
    );
        logic [PTR_MAX_W-1:0] mask_v;
        mask_v = {PTR_MAX_W{1'b1}} >> (unsigned'(PTR_MAX_W) - ptr_w);
        return (a - b) & mask_v;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO between the RAM read port and the output stream.
// Head word is held in a register so the output stays stable under backpressure.
module stream_skid_buf
    import dpram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    skid_state_e           state_r;
    logic [DATA_WIDTH-1:0] slot0_r;
    logic [DATA_WIDTH-1:0] slot1_r;
    logic                  valid_r;
    logic                  pop_s;

    assign pop_s     = valid_r & out_ready;
    assign out_valid = valid_r;
    assign out_data  = slot0_r;
    assign count     = state_r;

    // Occupancy state, head/tail slots and the registered valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= SKID_EMPTY;
            slot0_r <= {DATA_WIDTH{1'b0}};
            slot1_r <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (flush) begin
            state_r <= SKID_EMPTY;
            slot0_r <= {DATA_WIDTH{1'b0}};
            slot1_r <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (in_valid) begin
                        slot0_r <= in_data;
                        state_r <= SKID_ONE;
                        valid_r <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    case ({in_valid, pop_s})
                        2'b10: begin
                            slot1_r <= in_data;
                            state_r <= SKID_TWO;
                        end
                        2'b01: begin
                            state_r <= SKID_EMPTY;
                            valid_r <= 1'b0;
                        end
                        2'b11: begin
                            slot0_r <= in_data;
                        end
                        default: begin
                            state_r <= SKID_ONE;
                        end
                    endcase
                end
                SKID_TWO: begin
                    // The reader never fetches into a full buffer, so a push here always pairs with a pop.
                    if (pop_s) begin
                        slot0_r <= slot1_r;
                        if (in_valid) begin
                            slot1_r <= in_data;
                        end else begin
                            state_r <= SKID_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= SKID_EMPTY;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side controller for a dual-port RAM ring buffer: follows the writer pointer, fetches words
// through a registered-address RAM port and presents them as a valid/ready stream.
module dpram_stream_reader
    import dpram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = STREAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty
);

    localparam int              PTR_W   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] fetch_ptr_r;
    logic [ADDR_WIDTH:0] rd_ptr_r;
    logic                inflight_r;
    logic [1:0]          skid_cnt_s;
    logic [1:0]          occ_s;
    logic [1:0]          occ_after_pop_s;
    logic                pop_s;
    logic                issue_s;
    logic [ADDR_WIDTH:0] level_s;

    assign pop_s           = m_valid & m_ready;
    assign occ_s           = skid_cnt_s + {1'b0, inflight_r};
    assign occ_after_pop_s = occ_s - {1'b0, pop_s};
    // Fetch only when the word, once returned, is guaranteed a free buffer slot.
    assign issue_s         = (fetch_ptr_r != wr_ptr) && (occ_after_pop_s < 2'd2) && !flush;

    assign level_s   = PTR_W'(ptr_diff(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr_r), unsigned'(PTR_W)));
    assign level     = level_s;
    assign empty     = (level_s == {PTR_W{1'b0}});
    assign rd_ptr    = rd_ptr_r;
    assign ram_raddr = fetch_ptr_r[ADDR_WIDTH-1:0];

    // Fetch/consume pointers and the flag marking a meaningful word on ram_dout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            inflight_r  <= 1'b0;
        end else if (flush) begin
            fetch_ptr_r <= wr_ptr;
            rd_ptr_r    <= wr_ptr;
            inflight_r  <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fetch_ptr_r <= fetch_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (inflight_r),
        .in_data   (ram_dout),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .count     (skid_cnt_s)
    );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader with a registered-read RAM model.
module tb_dpram_stream_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          reset_n;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW:0]   level;
    logic          empty;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    dpram_stream_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: address sampled on the edge, data valid the following cycle.
    always @(posedge clk) ram_dout <= mem[ram_raddr];

    // Writer contract: never more than a full ring outstanding.
    always @(negedge clk) begin
        if (reset_n && (level > 6'd32)) check("ring_overrun", level, 64'd32);
    end

    function automatic logic [DW-1:0] exp_word(input int unsigned a);
        return 32'hA5A5_0001 + a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        wr_ptr  = 6'd0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5_0001 + i;
        reset_n = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        wr_ptr  = 6'd0;

        // Reset values, then a single word
        tick();
        tick();
        check("rst_m_valid", m_valid, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_rd_ptr", rd_ptr, 64'd0);
        check("rst_raddr", ram_raddr, 64'd0);
        check("rst_empty", empty, 64'd1);
        reset_n = 1'b1;
        wr_ptr  = 6'd1;
        tick();
        check("t1_valid_early", m_valid, 64'd0);
        check("t1_raddr_adv", ram_raddr, 64'd1);
        tick();
        check("t1_valid", m_valid, 64'd1);
        check("t1_data", m_data, 64'hA5A5_0001);
        check("t1_level", level, 64'd1);
        m_ready = 1'b1;
        tick();
        check("t1_valid_after_pop", m_valid, 64'd0);
        check("t1_rd_ptr", rd_ptr, 64'd1);
        check("t1_empty", empty, 64'd1);

        // Eight words at full throughput
        do_reset();
        wr_ptr  = 6'd8;
        m_ready = 1'b1;
        tick();
        check("t2_valid_early", m_valid, 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_valid", m_valid, 64'd1);
            check("t2_data", m_data, exp_word(i));
            check("t2_level", level, 64'(8 - i));
        end
        tick();
        check("t2_valid_end", m_valid, 64'd0);
        check("t2_rd_ptr", rd_ptr, 64'd8);
        check("t2_empty", empty, 64'd1);

        // Backpressure: two words fetched ahead, head frozen, then no bubble
        do_reset();
        wr_ptr = 6'd8;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 1) begin
                check("t3_hold_valid", m_valid, 64'd1);
                check("t3_hold_data", m_data, exp_word(0));
            end
        end
        check("t3_fetch_ahead", ram_raddr, 64'd2);
        check("t3_rd_ptr_hold", rd_ptr, 64'd0);
        check("t3_level_hold", level, 64'd8);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_valid", m_valid, 64'd1);
            check("t3_drain_data", m_data, exp_word(i));
            tick();
        end
        check("t3_valid_end", m_valid, 64'd0);
        check("t3_rd_ptr", rd_ptr, 64'd8);

        // Pointer wrap: 30 -> 34
        do_reset();
        wr_ptr = 6'd30;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_rd_ptr_start", rd_ptr, 64'd30);
        check("t4_raddr_start", ram_raddr, 64'd30);
        check("t4_valid_start", m_valid, 64'd0);
        wr_ptr  = 6'd34;
        m_ready = 1'b1;
        tick();
        check("t4_valid_early", m_valid, 64'd0);
        check("t4_raddr_next", ram_raddr, 64'd31);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_valid", m_valid, 64'd1);
            check("t4_data", m_data, exp_word((30 + i) % 32));
        end
        tick();
        check("t4_valid_end", m_valid, 64'd0);
        check("t4_rd_ptr", rd_ptr, 64'd34);
        check("t4_wrap_bit", rd_ptr[AW], 64'd1);
        check("t4_empty", empty, 64'd1);

        // Flush with two buffered words, a would-be issue, pop and writer increment
        do_reset();
        wr_ptr = 6'd8;
        repeat (3) tick();
        check("t5_pre_valid", m_valid, 64'd1);
        check("t5_pre_data", m_data, exp_word(0));
        flush   = 1'b1;
        m_ready = 1'b1;
        wr_ptr  = 6'd10;
        tick();
        flush = 1'b0;
        check("t5_valid", m_valid, 64'd0);
        check("t5_rd_ptr", rd_ptr, 64'd10);
        check("t5_fetch_ptr", ram_raddr, 64'd10);
        check("t5_empty", empty, 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_stale", m_valid, 64'd0);
        end
        wr_ptr = 6'd11;
        tick();
        check("t5_valid_early", m_valid, 64'd0);
        tick();
        check("t5_valid_new", m_valid, 64'd1);
        check("t5_data_new", m_data, exp_word(10));
        tick();
        check("t5_valid_end", m_valid, 64'd0);
        check("t5_rd_ptr_end", rd_ptr, 64'd11);

        // Asynchronous reset mid-stream
        do_reset();
        wr_ptr  = 6'd8;
        m_ready = 1'b1;
        repeat (4) tick();
        check("t6_pre_valid", m_valid, 64'd1);
        check("t6_pre_data", m_data, exp_word(2));
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", m_valid, 64'd0);
        check("t6_async_data", m_data, 64'd0);
        check("t6_async_rd_ptr", rd_ptr, 64'd0);
        check("t6_async_raddr", ram_raddr, 64'd0);
        check("t6_async_level", level, 64'd8);
        tick();
        reset_n = 1'b1;
        check("t6_rel_raddr", ram_raddr, 64'd0);
        tick();
        check("t6_rel_valid_early", m_valid, 64'd0);
        tick();
        check("t6_rel_valid", m_valid, 64'd1);
        check("t6_rel_data", m_data, exp_word(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
